// File: rtl/camera_control_pkg.sv
// camera_control_pkg
//   Shared types and helpers for the camera pose controller.
//   fp      : signed Q16.16 fixed point
//   vec3    : packed {x, y, z} of fp
//   KB_*    : bit indices into the 8-bit keyboard intent vector
//   fp_*    : wrapping add/sub/neg, truncating multiply, symmetric clamp
//   camera_state_t : pose-update FSM states
package camera_control_pkg;

    typedef logic signed [31:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    localparam fp FP_ONE           = 32'sd65536;
    localparam fp FP_HUNDREDTH     = 32'sd655;    // 0.01
    localparam fp FP_COS_HUNDREDTH = 32'sd65533;  // cos(0.01)
    localparam fp FP_SIN_HUNDREDTH = 32'sd655;    // sin(0.01)

    localparam vec3 RESET_POS = {32'sd0, FP_ONE, -32'sd98304};  // (0, 1, -1.5)
    localparam vec3 RESET_DIR = {32'sd0, 32'sd0, FP_ONE};       // (0, 0, 1)

    // Walk/turn group occupies [7:4], translate group [3:0].
    localparam int KB_TURN_L = 7;
    localparam int KB_TURN_R = 6;
    localparam int KB_FWD    = 5;
    localparam int KB_BACK   = 4;
    localparam int KB_LEFT   = 3;
    localparam int KB_RIGHT  = 2;
    localparam int KB_UP     = 1;
    localparam int KB_DOWN   = 0;

    // Intent after opposing pairs have cancelled.
    typedef struct packed {
        logic turn_l;
        logic turn_r;
        logic pitch_u;
        logic pitch_d;
        logic fwd;
        logic back;
        logic left;
        logic right;
        logic up;
        logic down;
    } intent_t;

    typedef enum logic [2:0] {
        CS_IDLE,
        CS_YAW,
        CS_PITCH,
        CS_MOVE,
        CS_COMMIT
    } camera_state_t;

    function automatic fp fp_add(input fp a, input fp b);
        return a + b;
    endfunction

    function automatic fp fp_sub(input fp a, input fp b);
        return a - b;
    endfunction

    function automatic fp fp_neg(input fp a);
        return -a;
    endfunction

    // Full 64-bit product, then drop 16 fraction bits (floor).
    function automatic fp fp_mul(input fp a, input fp b);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return p[47:16];
    endfunction

    function automatic fp fp_clamp(input fp v, input fp lim);
        if (v > lim)
            return lim;
        if (v < -lim)
            return -lim;
        return v;
    endfunction

endpackage

// File: rtl/camera_tick_gen.sv
// camera_tick_gen
//   Emits a one-cycle tick every (TICK_US*1000/CLK_PERIOD_NS)*(speed+1)
//   cycles. The speed multiplier is sampled on each tick and sets the
//   length of the following interval.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_speed        : tick period multiplier minus one
//   o_tick         : one-cycle tick pulse
module camera_tick_gen #(
    parameter int CLK_PERIOD_NS = 20,
    parameter int TICK_US       = 1000,
    parameter int SPEED_BITS    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [SPEED_BITS-1:0] i_speed,
    output logic                  o_tick
);

    localparam int unsigned BASE = (TICK_US * 1000) / CLK_PERIOD_NS;

    logic [31:0] r_cnt;
    logic [31:0] r_limit;

    assign o_tick = (r_cnt == r_limit);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_limit <= 32'(BASE - 1);
        end else if (o_tick) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            r_cnt   <= '0;
            r_limit <= BASE * (32'(i_speed) + 32'd1) - 32'd1;
        end else begin
            r_cnt   <= r_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/camera_control.sv
// camera_control
//   Frame-synchronous camera pose controller. Intent is merged from
//   buttons and keyboard; on each tick an FSM runs yaw, pitch and move
//   updates through one shared multiplier into a working pose, commits it
//   to a shadow pose, and the shadow is published only on frame_done_in.
//   Optional build macro: CAMERA_CONTROL_ACCEL_EN (hold-to-accelerate).
//   clk_in, rst_n_in     : clock, asynchronous active-low reset
//   btn_in {up,down,left,right}, kb_in, mode_in : motion intent
//   pitch_up_in/pitch_dn_in : pitch intent
//   speed_in             : tick period multiplier
//   preset_sel_in/preset_load_in : load a stored pose into the shadow
//   frame_done_in        : renderer frame boundary
//   pos_out/dir_out      : published pose
//   pose_updated_out     : pulses with each publish
//   busy_out             : FSM not in IDLE
module camera_control
    import camera_control_pkg::*;
#(
    parameter int CLK_PERIOD_NS = 20,
    parameter int TICK_US       = 1000,
    parameter int SPEED_BITS    = 2,
    parameter int EPS_SHIFT     = 7,
    parameter fp  PITCH_LIMIT   = 32'sd49152,  // 0.75
    parameter int NUM_PRESETS   = 4
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic [3:0]                     btn_in,
    input  logic [7:0]                     kb_in,
    input  logic                           mode_in,
    input  logic                           pitch_up_in,
    input  logic                           pitch_dn_in,
    input  logic [SPEED_BITS-1:0]          speed_in,
    input  logic [$clog2(NUM_PRESETS)-1:0] preset_sel_in,
    input  logic                           preset_load_in,
    input  logic                           frame_done_in,
    output vec3                            pos_out,
    output vec3                            dir_out,
    output logic                           pose_updated_out,
    output logic                           busy_out
);

    localparam fp STEP_EPS = FP_ONE >>> EPS_SHIFT;

    logic          w_tick;
    camera_state_t r_state, w_state_next;

    vec3 r_wpos, r_wdir;        // working pose, modified by the FSM
    vec3 r_spos, r_sdir;        // shadow pose, last committed result
    vec3 r_pos_out, r_dir_out;  // published pose
    vec3 r_preset_pos [NUM_PRESETS];
    vec3 r_preset_dir [NUM_PRESETS];

    logic [3:0] w_btn_map;
    logic [7:0] w_kb;
    intent_t    w_intent, r_intent;
    logic       w_move_now;
    logic       w_start;

    logic       r_parity, r_do_walk, r_pending, r_pose_updated;
    logic [1:0] r_sub;
    fp          r_yaw_x, r_yaw_z;
    fp          w_mul_a, w_mul_b, w_mul_p, w_move_step;

    camera_tick_gen #(
        .CLK_PERIOD_NS (CLK_PERIOD_NS),
        .TICK_US       (TICK_US),
        .SPEED_BITS    (SPEED_BITS)
    ) u_tick_gen (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_speed (speed_in),
        .o_tick  (w_tick)
    );

    // Buttons as {left, right, up, down} line up with both KB groups:
    // mode 0 -> {turn L, turn R, fwd, back}, mode 1 -> {left, right, up, down}.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_btn_map = {btn_in[1], btn_in[0], btn_in[3], btn_in[2]};
        w_kb      = kb_in | (mode_in ? {4'b0000, w_btn_map} : {w_btn_map, 4'b0000});
        w_intent         = '0;
        w_intent.turn_l  = w_kb[KB_TURN_L] & ~w_kb[KB_TURN_R];
        w_intent.turn_r  = w_kb[KB_TURN_R] & ~w_kb[KB_TURN_L];
        w_intent.pitch_u = pitch_up_in & ~pitch_dn_in;
        w_intent.pitch_d = pitch_dn_in & ~pitch_up_in;
        w_intent.fwd     = w_kb[KB_FWD]   & ~w_kb[KB_BACK];
        w_intent.back    = w_kb[KB_BACK]  & ~w_kb[KB_FWD];
        w_intent.left    = w_kb[KB_LEFT]  & ~w_kb[KB_RIGHT];
        w_intent.right   = w_kb[KB_RIGHT] & ~w_kb[KB_LEFT];
        w_intent.up      = w_kb[KB_UP]    & ~w_kb[KB_DOWN];
        w_intent.down    = w_kb[KB_DOWN]  & ~w_kb[KB_UP];
    end

    assign w_move_now = w_intent.fwd | w_intent.back | w_intent.left |
                        w_intent.right | w_intent.up | w_intent.down;

    // A preset load swallows any tick in the same cycle.
    assign w_start = (w_tick | r_pending) & (r_state == CS_IDLE) & ~preset_load_in;

`ifdef CAMERA_CONTROL_ACCEL_EN
    logic [5:0] r_hold, w_hold_next;
    logic [1:0] w_shift;
    fp          r_step, w_step_next;

    always_comb begin
        w_hold_next = '0;
        if (w_move_now)
            w_hold_next = (r_hold == 6'd63) ? r_hold : r_hold + 6'd1;
        w_shift     = (w_hold_next[5:4] > 2'd2) ? 2'd2 : w_hold_next[5:4];
        w_step_next = FP_HUNDREDTH <<< w_shift;
    end

    // Step is frozen for the whole sequence started by this tick.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_hold <= '0;
            r_step <= FP_HUNDREDTH;
        end else if (preset_load_in) begin
            r_hold <= '0;
        end else if (w_start) begin
            r_hold <= w_hold_next;
            r_step <= w_step_next;
        end
    end

    assign w_move_step = r_step;
`else
    assign w_move_step = FP_HUNDREDTH;
`endif

    // Shared multiplier operand select. The first yaw product (x*cos) is
    // formed in IDLE on the tick cycle, so YAW itself lasts three cycles.
    always_comb begin
        w_mul_a = r_wdir.x;
        w_mul_b = FP_COS_HUNDREDTH;
        case (r_state)
            CS_YAW: begin
                case (r_sub)
                    2'd1:    begin w_mul_a = r_wdir.z; w_mul_b = FP_SIN_HUNDREDTH; end
                    2'd2:    begin w_mul_a = r_wdir.x; w_mul_b = FP_SIN_HUNDREDTH; end
                    default: begin w_mul_a = r_wdir.z; w_mul_b = FP_COS_HUNDREDTH; end
                endcase
            end
            CS_MOVE: begin
                w_mul_a = (r_sub == 2'd0) ? r_wdir.z : r_wdir.x;
                w_mul_b = w_move_step;
            end
            default: ;
        endcase
        w_mul_p = fp_mul(w_mul_a, w_mul_b);
    end

    always_comb begin
        w_state_next = r_state;
        if (preset_load_in) begin
            w_state_next = CS_IDLE;
        end else begin
            case (r_state)
                CS_IDLE:   if (w_start)
                               w_state_next = (w_intent.turn_l | w_intent.turn_r) ? CS_YAW : CS_PITCH;
                CS_YAW:    if (r_sub == 2'd3) w_state_next = CS_PITCH;
                CS_PITCH:  w_state_next = CS_MOVE;
                CS_MOVE:   if (r_sub == 2'd1) w_state_next = CS_COMMIT;
                CS_COMMIT: w_state_next = CS_IDLE;
                default:   w_state_next = CS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            r_state <= CS_IDLE;
        else
            r_state <= w_state_next;
    end

    // Presets are read-only here and simply hold their reset contents.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            // NOTE: this small pose array is reset explicitly; large RAMs would not be.
            for (int i = 0; i < NUM_PRESETS; i++) begin
                r_preset_pos[i] <= RESET_POS;
                r_preset_dir[i] <= RESET_DIR;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wpos         <= RESET_POS;
            r_wdir         <= RESET_DIR;
            r_spos         <= RESET_POS;
            r_sdir         <= RESET_DIR;
            r_pos_out      <= RESET_POS;
            r_dir_out      <= RESET_DIR;
            r_pose_updated <= 1'b0;
            r_intent       <= '0;
            r_parity       <= 1'b0;
            r_do_walk      <= 1'b0;
            r_pending      <= 1'b0;
            r_sub          <= '0;
            r_yaw_x        <= '0;
            r_yaw_z        <= '0;
        end else begin
            r_pose_updated <= 1'b0;
            // Publish reads the shadow, so a mid-sequence frame sees the last commit.
            if (frame_done_in && ((r_spos != r_pos_out) || (r_sdir != r_dir_out))) begin
                r_pos_out      <= r_spos;
                r_dir_out      <= r_sdir;
                r_pose_updated <= 1'b1;
            end

            if (preset_load_in) begin
                r_wpos    <= r_preset_pos[preset_sel_in];
                r_wdir    <= r_preset_dir[preset_sel_in];
                r_spos    <= r_preset_pos[preset_sel_in];
                r_sdir    <= r_preset_dir[preset_sel_in];
                r_pending <= 1'b0;
            end else begin
                case (r_state)
                    CS_IDLE: begin
                        if (w_start) begin
                            r_pending <= 1'b0;
                            r_intent  <= w_intent;
                            r_do_walk <= ~r_parity;  // walk on even ticks, strafe on odd
                            r_parity  <= ~r_parity;
                            r_yaw_x   <= w_mul_p;    // x*cos
                            r_sub     <= 2'd1;
                        end
                    end
                    // Rotate about y: left is +0.01 rad.
                    // x' = x*cos -/+ z*sin, z' = +/- x*sin + z*cos
                    CS_YAW: begin
                        r_sub <= r_sub + 2'd1;
                        case (r_sub)
                            2'd1: r_yaw_x <= r_intent.turn_l ? fp_sub(r_yaw_x, w_mul_p)
                                                             : fp_add(r_yaw_x, w_mul_p);
                            2'd2: r_yaw_z <= r_intent.turn_l ? w_mul_p : fp_neg(w_mul_p);
                            default: begin
                                r_wdir.x <= r_yaw_x;
                                r_wdir.z <= fp_add(r_yaw_z, w_mul_p);
                            end
                        endcase
                    end
                    CS_PITCH: begin
                        r_sub <= 2'd0;
                        if (r_intent.pitch_u)
                            r_wdir.y <= fp_clamp(fp_add(r_wdir.y, STEP_EPS), PITCH_LIMIT);
                        else if (r_intent.pitch_d)
                            r_wdir.y <= fp_clamp(fp_sub(r_wdir.y, STEP_EPS), PITCH_LIMIT);
                    end
                    // Cycle 0 uses dir.z*step, cycle 1 uses dir.x*step.
                    // Walk: pos.xz -/+ dir.xz*step. Strafe right: +(dir.z, -dir.x)*step.
                    CS_MOVE: begin
                        r_sub <= r_sub + 2'd1;
                        if (r_sub == 2'd0) begin
                            if (r_intent.up)
                                r_wpos.y <= fp_add(r_wpos.y, STEP_EPS);
                            else if (r_intent.down)
                                r_wpos.y <= fp_sub(r_wpos.y, STEP_EPS);
                            if (r_do_walk) begin
                                if (r_intent.fwd)       r_wpos.z <= fp_sub(r_wpos.z, w_mul_p);
                                else if (r_intent.back) r_wpos.z <= fp_add(r_wpos.z, w_mul_p);
                            end else begin
                                if (r_intent.right)     r_wpos.x <= fp_add(r_wpos.x, w_mul_p);
                                else if (r_intent.left) r_wpos.x <= fp_sub(r_wpos.x, w_mul_p);
                            end
                        end else begin
                            if (r_do_walk) begin
                                if (r_intent.fwd)       r_wpos.x <= fp_sub(r_wpos.x, w_mul_p);
                                else if (r_intent.back) r_wpos.x <= fp_add(r_wpos.x, w_mul_p);
                            end else begin
                                if (r_intent.right)     r_wpos.z <= fp_sub(r_wpos.z, w_mul_p);
                                else if (r_intent.left) r_wpos.z <= fp_add(r_wpos.z, w_mul_p);
                            end
                        end
                    end
                    CS_COMMIT: begin
                        r_spos <= r_wpos;
                        r_sdir <= r_wdir;
                    end
                    default: ;
                endcase
                // Only one pending tick is remembered; extras are dropped.
                if (w_tick && (r_state != CS_IDLE))
                    r_pending <= 1'b1;
            end
        end
    end

    assign pos_out          = r_pos_out;
    assign dir_out          = r_dir_out;
    assign pose_updated_out = r_pose_updated;
    assign busy_out         = (r_state != CS_IDLE);

endmodule

// File: tb/tb_camera_control.sv
// tb_camera_control
//   Directed bench for camera_control with TICK_US=1 (50-cycle ticks).
//   Expected values are Q16.16 constants worked out by hand.
module tb_camera_control;
    import camera_control_pkg::*;

    logic       clk_in;
    logic       rst_n_in;
    logic [3:0] btn_in;
    logic [7:0] kb_in;
    logic       mode_in;
    logic       pitch_up_in;
    logic       pitch_dn_in;
    logic [1:0] speed_in;
    logic [1:0] preset_sel_in;
    logic       preset_load_in;
    logic       frame_done_in;
    vec3        pos_out;
    vec3        dir_out;
    logic       pose_updated_out;
    logic       busy_out;

    int n_cmp = 0;
    int n_bad = 0;

    camera_control #(.TICK_US(1)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .btn_in           (btn_in),
        .kb_in            (kb_in),
        .mode_in          (mode_in),
        .pitch_up_in      (pitch_up_in),
        .pitch_dn_in      (pitch_dn_in),
        .speed_in         (speed_in),
        .preset_sel_in    (preset_sel_in),
        .preset_load_in   (preset_load_in),
        .frame_done_in    (frame_done_in),
        .pos_out          (pos_out),
        .dir_out          (dir_out),
        .pose_updated_out (pose_updated_out),
        .busy_out         (busy_out)
    );

    initial clk_in = 1'b0;
    always #10 clk_in = ~clk_in;

    task automatic do_reset();
        btn_in = '0; kb_in = '0; mode_in = 1'b0; pitch_up_in = 1'b0; pitch_dn_in = 1'b0;
        speed_in = '0; preset_sel_in = '0; preset_load_in = 1'b0; frame_done_in = 1'b0;
        rst_n_in = 1'b1;
        #1 rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    // Counts FSM starts (busy rising edges); optionally waits for busy to drop.
    task automatic wait_ticks(input string name, input int n, input bit drain);
        int   seen = 0;
        int   cyc  = 0;
        int   budget;
        logic prev;
        budget = n * 60 + 100;
        prev   = busy_out;
        while (seen < n && cyc < budget) begin
            @(negedge clk_in); cyc++;
            if (busy_out && !prev) seen++;
            prev = busy_out;
        end
        while (drain && busy_out && cyc < budget) begin
            @(negedge clk_in); cyc++;
        end
        n_cmp++;
        if (seen != n || (drain && busy_out)) begin
            n_bad++;
            $display("FAIL %s_timeout: saw %0d sequences in %0d cycles, wanted %0d", name, seen, cyc, n);
        end
    endtask

    task automatic frame_pulse(output logic upd);
        @(negedge clk_in) frame_done_in = 1'b1;
        @(negedge clk_in) frame_done_in = 1'b0;
        upd = pose_updated_out;
    endtask

    task automatic test_reset();
        logic upd;
        do_reset();
        @(negedge clk_in);
        n_cmp++; if (pos_out !== {32'sd0, 32'sd65536, -32'sd98304}) begin n_bad++;
            $display("FAIL reset_pos: got %0d,%0d,%0d want 0,65536,-98304", pos_out.x, pos_out.y, pos_out.z); end
        n_cmp++; if (dir_out !== {32'sd0, 32'sd0, 32'sd65536}) begin n_bad++;
            $display("FAIL reset_dir: got %0d,%0d,%0d want 0,0,65536", dir_out.x, dir_out.y, dir_out.z); end
        n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        n_cmp++; if (pose_updated_out !== 1'b0) begin n_bad++;
            $display("FAIL reset_updated: got %b want 0", pose_updated_out); end
        for (int i = 0; i < 3; i++) begin
            repeat (40) @(negedge clk_in);
            frame_pulse(upd);
            n_cmp++; if (upd !== 1'b0) begin n_bad++; $display("FAIL idle_frame_%0d_updated: got %b want 0", i, upd); end
        end
        n_cmp++; if (pos_out !== {32'sd0, 32'sd65536, -32'sd98304} || dir_out !== {32'sd0, 32'sd0, 32'sd65536}) begin
            n_bad++; $display("FAIL idle_pose: got pos.z %0d dir.z %0d want -98304 65536", pos_out.z, dir_out.z); end
    endtask

    // Tick 1 walks (parity 0), tick 2 would strafe: z = -1.5 - 0.01.
    task automatic test_walk();
        logic upd;
        do_reset();
        kb_in = 8'h20;  // forward
        wait_ticks("walk", 2, 1'b1);
        kb_in = 8'h00;
        frame_pulse(upd);
        n_cmp++; if (upd !== 1'b1) begin n_bad++; $display("FAIL walk_updated: got %b want 1", upd); end
        n_cmp++; if (pos_out.z !== -32'sd98959) begin n_bad++;
            $display("FAIL walk_pos_z: got %0d want -98959", pos_out.z); end
        n_cmp++; if (pos_out.x !== 32'sd0 || pos_out.y !== 32'sd65536) begin n_bad++;
            $display("FAIL walk_pos_xy: got %0d,%0d want 0,65536", pos_out.x, pos_out.y); end
        @(negedge clk_in);
        n_cmp++; if (pose_updated_out !== 1'b0) begin n_bad++;
            $display("FAIL walk_pulse_width: got %b want 0", pose_updated_out); end
        frame_pulse(upd);
        n_cmp++; if (upd !== 1'b0) begin n_bad++; $display("FAIL walk_republish: got %b want 0", upd); end
    endtask

    task automatic test_cancel_and_vertical();
        logic upd;
        do_reset();
        kb_in = 8'h30;  // forward + back cancel
        wait_ticks("cancel", 1, 1'b1);
        kb_in = 8'h00;
        frame_pulse(upd);
        n_cmp++; if (upd !== 1'b0) begin n_bad++; $display("FAIL cancel_updated: got %b want 0", upd); end
        mode_in = 1'b1;
        btn_in  = 4'b1000;  // up button -> vertical up in translate mode
        wait_ticks("vertical", 1, 1'b1);
        btn_in  = 4'b0000;
        frame_pulse(upd);
        n_cmp++; if (pos_out.y !== 32'sd66048 || upd !== 1'b1) begin n_bad++;
            $display("FAIL vertical_pos_y: got %0d upd %b want 66048 upd 1", pos_out.y, upd); end
    endtask

    task automatic test_turn();
        logic upd;
        int   busy_cycles;
        do_reset();
        kb_in = 8'h80;  // turn left
        wait_ticks("turn", 1, 1'b0);
        busy_cycles = 1;
        while (busy_out && busy_cycles < 20) begin
            @(negedge clk_in);
            if (busy_out) busy_cycles++;
        end
        kb_in = 8'h00;
        n_cmp++; if (busy_cycles != 7) begin n_bad++;
            $display("FAIL turn_busy_cycles: got %0d want 7", busy_cycles); end
        n_cmp++; if (pos_out !== {32'sd0, 32'sd65536, -32'sd98304} || dir_out !== {32'sd0, 32'sd0, 32'sd65536}) begin
            n_bad++; $display("FAIL turn_prepublish: got dir.x %0d dir.z %0d want 0 65536", dir_out.x, dir_out.z); end
        frame_pulse(upd);
        n_cmp++; if (upd !== 1'b1) begin n_bad++; $display("FAIL turn_updated: got %b want 1", upd); end
        n_cmp++; if (dir_out.x !== -32'sd655 || dir_out.z !== 32'sd65533 || dir_out.y !== 32'sd0) begin n_bad++;
            $display("FAIL turn_dir: got %0d,%0d,%0d want -655,0,65533", dir_out.x, dir_out.y, dir_out.z); end
    endtask

    task automatic test_pitch();
        logic upd;
        do_reset();
        pitch_up_in = 1'b1;
        wait_ticks("pitch50", 50, 1'b1);
        frame_pulse(upd);
        n_cmp++; if (dir_out.y !== 32'sd25600) begin n_bad++;
            $display("FAIL pitch_mid: got %0d want 25600", dir_out.y); end
        wait_ticks("pitch200", 150, 1'b1);
        pitch_up_in = 1'b0;
        frame_pulse(upd);
        n_cmp++; if (dir_out.y !== 32'sd49152) begin n_bad++;
            $display("FAIL pitch_clamp: got %0d want 49152", dir_out.y); end
    endtask

    task automatic test_preset_abort();
        logic upd;
        do_reset();
        kb_in = 8'h80;
        wait_ticks("preset_turn", 1, 1'b1);
        frame_pulse(upd);
        n_cmp++; if (dir_out.x !== -32'sd655) begin n_bad++;
            $display("FAIL preset_pre_dir_x: got %0d want -655", dir_out.x); end
        wait_ticks("preset_yaw", 1, 1'b0);  // now in YAW
        kb_in = 8'h00;
        preset_sel_in  = 2'd0;
        preset_load_in = 1'b1;
        @(negedge clk_in);
        preset_load_in = 1'b0;
        n_cmp++; if (busy_out !== 1'b0) begin n_bad++;
            $display("FAIL preset_abort_busy: got %b want 0", busy_out); end
        frame_pulse(upd);
        n_cmp++; if (upd !== 1'b1) begin n_bad++; $display("FAIL preset_updated: got %b want 1", upd); end
        n_cmp++; if (dir_out !== {32'sd0, 32'sd0, 32'sd65536} || pos_out !== {32'sd0, 32'sd65536, -32'sd98304}) begin
            n_bad++; $display("FAIL preset_pose: got dir %0d,%0d,%0d want 0,0,65536", dir_out.x, dir_out.y, dir_out.z); end
    endtask

    // 40 forward ticks, walking on odd tick numbers only.
    // Constant step: 20*655. Accelerated: 8*655 + 8*1310 + 4*2620.
    task automatic test_walk_long();
        logic upd;
        fp    exp_z;
`ifdef CAMERA_CONTROL_ACCEL_EN
        exp_z = -32'sd124504;
`else
        exp_z = -32'sd111404;
`endif
        do_reset();
        kb_in = 8'h20;
        wait_ticks("walk_long", 40, 1'b1);
        kb_in = 8'h00;
        frame_pulse(upd);
        n_cmp++; if (pos_out.z !== exp_z) begin n_bad++;
            $display("FAIL walk_long_z: got %0d want %0d", pos_out.z, exp_z); end
        n_cmp++; if (pos_out.x !== 32'sd0) begin n_bad++;
            $display("FAIL walk_long_x: got %0d want 0", pos_out.x); end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_cancel_and_vertical();
        test_turn();
        test_pitch();
        test_preset_abort();
        test_walk_long();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
